pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage. It supersedes the fixed 32-bit PC register. It adds a stall hold, a prioritised redirect (exception, ERET, branch/jump), and capture of redirects that arrive while fetch is stalled. It sits at the head of IF, drives the instruction-memory address, and receives redirect requests from ID/EX/MEM and the CP0 logic.

## Interface
Parameters:
- AW, 32, PC width in bits (≥ 8).
- RESET_VEC, 32'hBFC00000, PC value loaded on reset (truncated to AW).
- EXC_VEC, 32'hBFC00380, exception entry address.
- STEP, 4, sequential increment.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Stall  in  1  hold PC this cycle.
- BrEn  in  1  branch/jump redirect request.
- BrTarget  in  AW  branch/jump target.
- EretEn  in  1  return-from-exception request.
- EpcIn  in  AW  ERET target (CP0 EPC).
- ExcEn  in  1  exception request; target is EXC_VEC.
- PCReg  out  AW  current fetch address.
- PCRegP4  out  AW  PCReg + STEP, combinational, wraps modulo 2^AW.
- PCValid  out  1  PCReg is a fetchable address.
- RedirPending  out  1  a redirect is captured and waiting for Stall to release.
- MisalignErr  out  1  PCReg[1:0] != 0, combinational.

## Operation
- Request priority within a cycle: ExcEn > EretEn > BrEn. Incoming target = EXC_VEC / EpcIn / BrTarget, with rank 3/2/1 (0 = none).
- The block has a pending register: PendRank (2 bits) and PendTarget (AW bits).
- Not stalled (Stall=0), at each rising edge:
  - An incoming request with rank ≥ PendRank loads its target into PCReg.
  - Otherwise, if PendRank≠0, PCReg ← PendTarget.
  - Otherwise PCReg ← PCRegP4.
  - Pending is cleared in all three cases.
- Stalled (Stall=1):
  - PCReg holds.
  - An incoming request with rank ≥ PendRank overwrites PendRank/PendTarget.
  - A lower-rank request is dropped.
- RedirPending = (PendRank≠0).
- PCValid: 0 out of reset; 1 from the first rising edge after Rst deasserts; stays 1 thereafter.
- Arithmetic is unsigned at AW bits; the PCRegP4 carry-out is discarded.
- A misaligned target is loaded unchanged. MisalignErr flags it for the CP0 AdEL path; the block takes no further action.

## Timing
- Reset (Rst=0), immediately and asynchronously:
  - PCReg=RESET_VEC, PCRegP4=RESET_VEC+STEP.
  - PendRank=0, RedirPending=0, PCValid=0.
  - MisalignErr=0 for the default RESET_VEC.
- Reset asserted mid-stall or with a redirect pending discards the pending redirect.
- Redirect latency: a request present at edge N (Stall=0) appears on PCReg after edge N. There is no delay-slot handling here; ID issues BrEn at the correct cycle.
- Redirect during stall: PCReg reflects the captured target on the first edge where Stall=0.
- Same-cycle Stall release plus a new request: the higher-or-equal-rank new request wins; on a tie the new request wins.
- Multiple requests across stall cycles: the last request of the highest rank seen is retained.
- PCRegP4 and MisalignErr are combinational from PCReg, with zero-cycle latency.

## Test plan
- Reset, release, no requests for 3 cycles → PCReg = BFC00000, BFC00004, BFC00008, BFC0000C; PCValid=1 from the first edge.
- BrEn=1, BrTarget=80001000, Stall=0 → PCReg=80001000 on the next edge, then 80001004.
- Stall=1 for 3 cycles with BrEn pulsed (target 80002000) in cycle 1 → PCReg holds and RedirPending=1; on release PCReg=80002000 and RedirPending=0.
- During a stall: ExcEn in cycle 1, then BrEn (80003000) in cycle 2 → branch dropped; on release PCReg=BFC00380.
- ExcEn, EretEn (EpcIn=80004000) and BrEn all asserted together, Stall=0 → PCReg=BFC00380. Then EretEn alone → PCReg=80004000.
- Further checks:
  - AW=16, RESET_VEC=FFFC, two free-running edges → PCReg=FFFC then 0000 (wrap).
  - BrTarget=80000002 → MisalignErr=1.
  - Rst pulsed low mid-stall with a redirect pending → RedirPending=0 and PCReg=RESET_VEC.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the redirect sources and the PC generator.
// Master drives the requests; slave returns the current fetch address.
interface pc_gen_if #(
    parameter int AW = 32
);
    logic          Stall;
    logic          BrEn;
    logic [AW-1:0] BrTarget;
    logic          EretEn;
    logic [AW-1:0] EpcIn;
    logic          ExcEn;
    logic [AW-1:0] PCReg;
    logic [AW-1:0] PCRegP4;
    logic          PCValid;
    logic          RedirPending;
    logic          MisalignErr;

    modport master (
        output Stall, BrEn, BrTarget,
        output EretEn, EpcIn, ExcEn,
        input  PCReg, PCRegP4, PCValid,
        input  RedirPending, MisalignErr
    );

    modport slave (
        input  Stall, BrEn, BrTarget,
        input  EretEn, EpcIn, ExcEn,
        output PCReg, PCRegP4, PCValid,
        output RedirPending, MisalignErr
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program counter with stall hold and prioritised redirects.
// Redirects seen while stalled are parked until the stall releases.
module pc_gen #(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_VEC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter int          STEP      = 4
) (
    input  logic      Clk,
    input  logic      Rst,
    pc_gen_if.slave   pc_bus
);

    localparam logic [AW-1:0] RST_PC = AW'(RESET_VEC);
    localparam logic [AW-1:0] EXC_PC = AW'(EXC_VEC);
    localparam logic [AW-1:0] INC    = AW'(STEP);

    logic [AW-1:0] r_pc;
    logic [1:0]    r_pend_rank;
    logic [AW-1:0] r_pend_tgt;
    logic          r_valid;

    logic [1:0]    w_in_rank;
    logic [AW-1:0] w_in_tgt;
    logic          w_take;
    logic [AW-1:0] w_pc_inc;

    // Rank 3/2/1 = exception/ERET/branch; 0 means no request.
    always_comb begin
        w_in_rank = 2'd0;
        w_in_tgt  = pc_bus.BrTarget;
        unique case (1'b1)
            pc_bus.ExcEn: begin
                w_in_rank = 2'd3;
                w_in_tgt  = EXC_PC;
            end
            !pc_bus.ExcEn && pc_bus.EretEn: begin
                w_in_rank = 2'd2;
                w_in_tgt  = pc_bus.EpcIn;
            end
            !pc_bus.ExcEn && !pc_bus.EretEn
                && pc_bus.BrEn: begin
                w_in_rank = 2'd1;
                w_in_tgt  = pc_bus.BrTarget;
            end
            default: begin
                w_in_rank = 2'd0;
                w_in_tgt  = pc_bus.BrTarget;
            end
        endcase
    end

    // Ties go to the newer request.
    assign w_take = (w_in_rank != 2'd0)
                 && (w_in_rank >= r_pend_rank);

    assign w_pc_inc = r_pc + INC;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc        <= RST_PC;
            r_pend_rank <= 2'd0;
            r_pend_tgt  <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (!pc_bus.Stall) begin
                if (w_take) begin
                    r_pc <= w_in_tgt;
                end else if (r_pend_rank != 2'd0) begin
                    r_pc <= r_pend_tgt;
                end else begin
                    r_pc <= w_pc_inc;
                end
                r_pend_rank <= 2'd0;
            end else if (w_take) begin
                r_pend_rank <= w_in_rank;
                r_pend_tgt  <= w_in_tgt;
            end
        end
    end

    assign pc_bus.PCReg        = r_pc;
    assign pc_bus.PCRegP4      = w_pc_inc;
    assign pc_bus.PCValid      = r_valid;
    assign pc_bus.RedirPending = (r_pend_rank != 2'd0);
    assign pc_bus.MisalignErr  = |r_pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random
// requests, compared every cycle against a behavioural model.
module tb_pc_gen;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    pc_gen_if #(.AW(32)) bus ();
    pc_gen_if #(.AW(16)) bus16 ();

    pc_gen #(.AW(32)) u_dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .pc_bus (bus)
    );

    pc_gen #(
        .AW        (16),
        .RESET_VEC (32'h0000FFFC)
    ) u_dut16 (
        .Clk    (Clk),
        .Rst    (Rst),
        .pc_bus (bus16)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc;
    int          m_prank;
    logic [31:0] m_ptgt;
    bit          m_valid;

    task automatic check(string nm, logic [31:0] act,
                         logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("PCReg", bus.PCReg, m_pc);
            check("PCRegP4", bus.PCRegP4, m_pc + 32'd4);
            check("PCValid", 32'(bus.PCValid), 32'(m_valid));
            check("RedirPending", 32'(bus.RedirPending),
                  32'(m_prank != 0));
            check("MisalignErr", 32'(bus.MisalignErr),
                  32'(m_pc[1:0] != 2'b00));
        end
    end

    task automatic model_reset();
        m_pc    = 32'hBFC00000;
        m_prank = 0;
        m_ptgt  = '0;
        m_valid = 1'b0;
    endtask

    // Pick the winning incoming request, then apply stall/pending rules.
    task automatic model_edge();
        int          r;
        logic [31:0] t;
        r = 0;
        t = '0;
        if (bus.ExcEn) begin
            r = 3; t = 32'hBFC00380;
        end else if (bus.EretEn) begin
            r = 2; t = bus.EpcIn;
        end else if (bus.BrEn) begin
            r = 1; t = bus.BrTarget;
        end
        if (!bus.Stall) begin
            if (r > 0 && r >= m_prank) m_pc = t;
            else if (m_prank > 0) m_pc = m_ptgt;
            else m_pc = m_pc + 32'd4;
            m_prank = 0;
        end else if (r > 0 && r >= m_prank) begin
            m_prank = r;
            m_ptgt  = t;
        end
        m_valid = 1'b1;
    endtask

    task automatic cyc(bit st, bit br, logic [31:0] bt,
                       bit er, logic [31:0] epc, bit ex);
        bus.Stall    = st;
        bus.BrEn     = br;
        bus.BrTarget = bt;
        bus.EretEn   = er;
        bus.EpcIn    = epc;
        bus.ExcEn    = ex;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        model_reset();
        #1;
        check("rst PCReg", bus.PCReg, 32'hBFC00000);
        check("rst PCRegP4", bus.PCRegP4, 32'hBFC00004);
        check("rst PCValid", 32'(bus.PCValid), 0);
        check("rst RedirPending", 32'(bus.RedirPending), 0);
        check("rst MisalignErr", 32'(bus.MisalignErr), 0);
        @(posedge Clk);
        @(negedge Clk);
        #2;
        Rst = 1'b1;
    endtask

    initial begin
        bus.Stall    = 1'b0;
        bus.BrEn     = 1'b0;
        bus.BrTarget = '0;
        bus.EretEn   = 1'b0;
        bus.EpcIn    = '0;
        bus.ExcEn    = 1'b0;
        bus16.Stall    = 1'b0;
        bus16.BrEn     = 1'b0;
        bus16.BrTarget = '0;
        bus16.EretEn   = 1'b0;
        bus16.EpcIn    = '0;
        bus16.ExcEn    = 1'b0;
        model_reset();
        @(negedge Clk);
        #2;
        do_reset();
        chk_en = 1'b1;
        check("w16 rst PCReg", 32'(bus16.PCReg), 32'h0000FFFC);
        check("w16 rst PCRegP4", 32'(bus16.PCRegP4), 32'h0);

        // Free-running after reset
        idle();
        check("seq1", bus.PCReg, 32'hBFC00004);
        check("valid1", 32'(bus.PCValid), 1);
        check("w16 wrap", 32'(bus16.PCReg), 32'h0);
        idle();
        check("seq2", bus.PCReg, 32'hBFC00008);
        idle();
        check("seq3", bus.PCReg, 32'hBFC0000C);

        // Unstalled branch
        cyc(0, 1, 32'h80001000, 0, '0, 0);
        check("br", bus.PCReg, 32'h80001000);
        idle();
        check("br+4", bus.PCReg, 32'h80001004);

        // Branch captured during a stall
        cyc(1, 1, 32'h80002000, 0, '0, 0);
        check("st hold", bus.PCReg, 32'h80001004);
        check("st pend", 32'(bus.RedirPending), 1);
        cyc(1, 0, '0, 0, '0, 0);
        cyc(1, 0, '0, 0, '0, 0);
        idle();
        check("st rel", bus.PCReg, 32'h80002000);
        check("st clr", 32'(bus.RedirPending), 0);

        // Lower-rank branch dropped behind a parked exception
        cyc(1, 0, '0, 0, '0, 1);
        cyc(1, 1, 32'h80003000, 0, '0, 0);
        idle();
        check("exc wins", bus.PCReg, 32'hBFC00380);

        // Same-cycle priority, then ERET alone
        cyc(0, 1, 32'h80005000, 1, 32'h80004000, 1);
        check("prio", bus.PCReg, 32'hBFC00380);
        cyc(0, 0, '0, 1, 32'h80004000, 0);
        check("eret", bus.PCReg, 32'h80004000);

        // Misaligned target loaded as-is
        cyc(0, 1, 32'h80000002, 0, '0, 0);
        check("mis pc", bus.PCReg, 32'h80000002);
        check("mis err", 32'(bus.MisalignErr), 1);

        // Reset with a redirect parked
        cyc(1, 1, 32'h80006000, 0, '0, 0);
        check("pre-rst pend", 32'(bus.RedirPending), 1);
        do_reset();
        idle();
        check("post-rst", bus.PCReg, 32'hBFC00004);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          st, br, er, ex;
            logic [31:0] bt, epc;
            st  = ($urandom_range(0, 99) < 45);
            br  = ($urandom_range(0, 99) < 25);
            er  = ($urandom_range(0, 99) < 10);
            ex  = ($urandom_range(0, 99) < 6);
            bt  = $urandom;
            epc = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                bt[1:0]  = 2'b00;
                epc[1:0] = 2'b00;
            end
            cyc(st, br, bt, er, epc, ex);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
